// File: rtl/line_window_3x3_if.sv
// line_window_3x3 pixel-in / window-out bundle.
// slave = window generator, master = pixel source and window consumer.
interface line_window_3x3_if #(
  parameter int Datawidth = 8,
  parameter int Img_W     = 512,
  parameter int Img_H     = 512
);
  logic [Datawidth-1:0]     in_pix;
  logic                     in_valid;
  logic                     in_ready;
  logic [9*Datawidth-1:0]   win_data;
  logic                     win_valid;
  logic [$clog2(Img_H)-1:0] win_row;
  logic [$clog2(Img_W)-1:0] win_col;
  logic                     frame_done;

  modport slave (
    input  in_pix,
    input  in_valid,
    output in_ready,
    output win_data,
    output win_valid,
    output win_row,
    output win_col,
    output frame_done
  );

  modport master (
    output in_pix,
    output in_valid,
    input  in_ready,
    input  win_data,
    input  win_valid,
    input  win_row,
    input  win_col,
    input  frame_done
  );
endinterface

// File: rtl/line_window_3x3.sv
// Streaming 3x3 window generator, two line RAMs plus a 3x3 shift window.
// Define LINE_WINDOW_REPLICATE_EN for edge replication instead of zero pad.
module line_window_3x3 #(
  parameter int Datawidth = 8,
  parameter int Img_W     = 512,
  parameter int Img_H     = 512
) (
  input  logic            clk,
  input  logic            reset,
  line_window_3x3_if.slave io
);
  localparam int CW = $clog2(Img_W);
  localparam int RW = $clog2(Img_H);
  localparam int DW = Datawidth;
  localparam logic [CW-1:0] C_LAST = CW'(Img_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(Img_H - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);

`ifdef LINE_WINDOW_REPLICATE_EN
  localparam bit Rep = 1'b1;
`else
  localparam bit Rep = 1'b0;
`endif

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FLUSH
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] cin_q, cin_d;
  logic [RW-1:0] rin_q, rin_d;
  logic [CW-1:0] ccol_q, ccol_d;
  logic [RW-1:0] crow_q, crow_d;
  logic          rdy_q, rdy_d;

  logic [DW-1:0] tap_q [3][3];
  logic [DW-1:0] tap_d [3][3];
  logic [DW-1:0] rowp  [3][3];
  logic [DW-1:0] padw  [3][3];
  logic [DW-1:0] colv  [3];

  logic [9*DW-1:0] win_q, win_d;
  logic            vld_q, vld_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            done_q, done_d;

  logic [DW-1:0] lb0 [Img_W];
  logic [DW-1:0] lb1 [Img_W];

  logic acc, adv, emit;
  logic last_in, last_ctr;
  logic top, bot, left, right;

  always_comb begin
    acc      = rdy_q && io.in_valid && (state_q != FLUSH);
    adv      = acc || (state_q == FLUSH);
    emit     = adv && (state_q != FILL);
    last_in  = (rin_q == R_LAST) && (cin_q == C_LAST);
    last_ctr = (crow_q == R_LAST) && (ccol_q == C_LAST);
  end

  always_comb begin
    state_d = state_q;
    cin_d   = cin_q;
    rin_d   = rin_q;
    ccol_d  = ccol_q;
    crow_d  = crow_q;
    if (adv) begin
      cin_d = (cin_q == C_LAST) ? '0 : cin_q + 1'b1;
      if (cin_q == C_LAST)
        rin_d = (rin_q == R_LAST) ? '0 : rin_q + 1'b1;
    end
    if (emit) begin
      ccol_d = (ccol_q == C_LAST) ? '0 : ccol_q + 1'b1;
      if (ccol_q == C_LAST)
        crow_d = (crow_q == R_LAST) ? '0 : crow_q + 1'b1;
    end
    unique case (state_q)
      FILL: begin
        if (acc && rin_q == R_ONE && cin_q == '0)
          state_d = RUN;
      end
      RUN: begin
        if (acc && last_in)
          state_d = FLUSH;
      end
      FLUSH: begin
        // frame end: realign input and centre counters
        if (last_ctr) begin
          state_d = FILL;
          cin_d   = '0;
          rin_d   = '0;
          ccol_d  = '0;
          crow_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
    rdy_d  = (state_d != FLUSH);
    done_d = emit && (state_q == FLUSH) && last_ctr;
  end

  always_comb begin
    colv[0] = lb1[cin_q];
    colv[1] = lb0[cin_q];
    colv[2] = (state_q == FLUSH) ? '0 : io.in_pix;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        tap_d[r][c] = tap_q[r][c];
      end
      if (adv) begin
        tap_d[r][0] = tap_q[r][1];
        tap_d[r][1] = tap_q[r][2];
        tap_d[r][2] = colv[r];
      end
    end
  end

  always_comb begin
    top   = (crow_q == '0);
    bot   = (crow_q == R_LAST);
    left  = (ccol_q == '0);
    right = (ccol_q == C_LAST);
    // rows first, then columns, so corners resolve to the centre pixel
    for (int c = 0; c < 3; c++) begin
      rowp[1][c] = tap_d[1][c];
      rowp[0][c] = top ? (Rep ? tap_d[1][c] : '0) : tap_d[0][c];
      rowp[2][c] = bot ? (Rep ? tap_d[1][c] : '0) : tap_d[2][c];
    end
    for (int r = 0; r < 3; r++) begin
      padw[r][1] = rowp[r][1];
      padw[r][0] = left  ? (Rep ? rowp[r][1] : '0) : rowp[r][0];
      padw[r][2] = right ? (Rep ? rowp[r][1] : '0) : rowp[r][2];
    end
  end

  always_comb begin
    win_d = win_q;
    row_d = row_q;
    col_d = col_q;
    vld_d = emit;
    if (emit) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_d[(3*r+c)*DW +: DW] = padw[r][c];
        end
      end
      row_d = crow_q;
      col_d = ccol_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      cin_q   <= '0;
      rin_q   <= '0;
      ccol_q  <= '0;
      crow_q  <= '0;
      rdy_q   <= 1'b0;
      win_q   <= '0;
      vld_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tap_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      cin_q   <= cin_d;
      rin_q   <= rin_d;
      ccol_q  <= ccol_d;
      crow_q  <= crow_d;
      rdy_q   <= rdy_d;
      win_q   <= win_d;
      vld_q   <= vld_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tap_q[r][c] <= tap_d[r][c];
        end
      end
    end
  end

  // line RAMs are never cleared; edge padding hides stale rows
  always_ff @(posedge clk) begin
    if (adv) begin
      lb1[cin_q] <= lb0[cin_q];
      lb0[cin_q] <= colv[2];
    end
  end

  assign io.in_ready   = rdy_q;
  assign io.win_data   = win_q;
  assign io.win_valid  = vld_q;
  assign io.win_row    = row_q;
  assign io.win_col    = col_q;
  assign io.frame_done = done_q;
endmodule

// File: tb/tb_line_window_3x3.sv
// Random-stimulus bench for line_window_3x3 (4x3 image, 8-bit pixels).
// Windows are predicted from stored frames by direct neighbourhood lookup.
module tb_line_window_3x3;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic clk;
  logic reset;

  line_window_3x3_if #(.Datawidth(DW), .Img_W(W), .Img_H(H)) io ();

  line_window_3x3 #(.Datawidth(DW), .Img_W(W), .Img_H(H)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;
  logic [7:0]  pix_store [32][N];
  logic [71:0] cap [256];
  int wr_frame;
  int mon_frame;
  int mon_idx;
  int win_total;
  int frames_seen;
  int rdy_low;
  logic prev_ok;

  task automatic check(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int a0, a1, a2, a3, a4,
                                        a5, a6, a7, a8);
    logic [71:0] w;
    w = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4),
         8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    return w;
  endfunction

  function automatic logic [71:0] model(input int f, input int r,
                                        input int c);
    logic [71:0] w;
    logic [7:0]  v;
    int rr, cc;
    w = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        rr = r + dr - 1;
        cc = c + dc - 1;
`ifdef LINE_WINDOW_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr > H - 1) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc > W - 1) cc = W - 1;
        v = pix_store[f][rr*W+cc];
`else
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) v = 8'h00;
        else v = pix_store[f][rr*W+cc];
`endif
        w[(3*dr+dc)*8 +: 8] = v;
      end
    end
    return w;
  endfunction

  task automatic monitor();
    logic [71:0] exp;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_valid", 72'(io.win_valid), 0);
        check("rst_data", io.win_data, 0);
        check("rst_row", 72'(io.win_row), 0);
        check("rst_col", 72'(io.win_col), 0);
        check("rst_done", 72'(io.frame_done), 0);
        check("rst_ready", 72'(io.in_ready), 0);
        mon_idx   = 0;
        mon_frame = wr_frame;
        prev_ok   = 1'b0;
      end else begin
        if (!io.in_ready) rdy_low++;
        if (io.win_valid) begin
          check("valid_cause", 72'(prev_ok), 1);
          exp = model(mon_frame, mon_idx / W, mon_idx % W);
          check("win_data", io.win_data, exp);
          check("win_row", 72'(io.win_row), 72'(mon_idx / W));
          check("win_col", 72'(io.win_col), 72'(mon_idx % W));
          check("frame_done", 72'(io.frame_done),
                72'(mon_idx == N - 1));
          cap[win_total & 255] = io.win_data;
          win_total++;
          mon_idx++;
          if (mon_idx == N) begin
            mon_idx = 0;
            mon_frame++;
          end
        end else begin
          check("done_no_valid", 72'(io.frame_done), 0);
        end
        if (io.frame_done) frames_seen++;
        // a window may only follow an accept or a non-ready (flush) cycle
        prev_ok = (io.in_valid && io.in_ready) || !io.in_ready;
      end
    end
  endtask

  task automatic drive_pix(input logic [7:0] p);
    int g;
    io.in_pix   = p;
    io.in_valid = 1'b1;
    g = 0;
    while (!io.in_ready && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 200) check("ready_timeout", 72'(io.in_ready), 1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input int mode,
                            input int npix);
    int f;
    f = wr_frame;
    for (int k = 0; k < N; k++) begin
      if (base >= 0) pix_store[f][k] = 8'(base + k);
      else pix_store[f][k] = 8'($urandom_range(0, 255));
    end
    wr_frame++;
    for (int k = 0; k < npix; k++) begin
      drive_pix(pix_store[f][k]);
      if (mode == 1) begin
        @(posedge clk);
        #1;
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_frames(input int target);
    int g;
    g = 0;
    while (frames_seen < target && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("frame_count", 72'(frames_seen), 72'(target));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic directed(input int s);
    logic [71:0] w;
`ifdef LINE_WINDOW_REPLICATE_EN
    check("w00", cap[s], pack9(1, 1, 2, 1, 1, 2, 5, 5, 6));
    check("w23", cap[s+11], pack9(7, 8, 8, 11, 12, 12, 11, 12, 12));
`else
    check("w00", cap[s], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    check("w23", cap[s+11], pack9(7, 8, 0, 11, 12, 0, 0, 0, 0));
    w = cap[s+4];
    check("left_pad", 72'({w[55:48], w[31:24], w[7:0]}), 0);
    w = cap[s+7];
    check("right_pad", 72'({w[71:64], w[47:40], w[23:16]}), 0);
`endif
    check("w11", cap[s+5], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
  endtask

  initial begin
    int s;
    int r0;
    n_chk = 0;
    n_err = 0;
    wr_frame = 0;
    mon_frame = 0;
    mon_idx = 0;
    win_total = 0;
    frames_seen = 0;
    rdy_low = 0;
    prev_ok = 1'b0;
    io.in_pix = '0;
    io.in_valid = 1'b0;
    reset = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    s  = win_total;
    r0 = rdy_low;
    send_frame(1, 0, N);
    wait_frames(1);
    check("flush_ready_low", 72'(rdy_low - r0), 5);
    check("s1_windows", 72'(win_total - s), 12);
    directed(s);

    s = win_total;
    send_frame(1, 1, N);
    wait_frames(2);
    check("s2_windows", 72'(win_total - s), 12);
    directed(s);

    s = win_total;
    send_frame(1, 0, N);
    send_frame(101, 0, N);
    wait_frames(4);
    check("s3_windows", 72'(win_total - s), 24);
`ifdef LINE_WINDOW_REPLICATE_EN
    check("f2_w00", cap[s+12],
          pack9(101, 101, 102, 101, 101, 102, 105, 105, 106));
`else
    check("f2_w00", cap[s+12], pack9(0, 0, 0, 0, 101, 102, 0, 105, 106));
`endif

    send_frame(1, 0, 7);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    s = win_total;
    send_frame(1, 0, N);
    wait_frames(5);
    check("s4_windows", 72'(win_total - s), 12);
    directed(s);

    s = win_total;
    for (int f = 0; f < 6; f++) begin
      send_frame(-1, (f % 2 == 0) ? 2 : 0, N);
    end
    wait_frames(11);
    check("rand_windows", 72'(win_total - s), 72);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
